// File: rtl/count_wrap_monitor_if.sv
// Bundle between a free-running counter and its wrap monitor.
// master: the side that produces count and observes the monitor results.
// slave:  the monitor itself.
interface count_wrap_monitor_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
);
    logic [WIDTH-1:0]  count;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic              stalled;
    logic              jump_err;
    logic [1:0]        state;

    modport master (
        output count,
        input  wrap_pulse,
        input  wrap_count,
        input  stalled,
        input  jump_err,
        input  state
    );

    modport slave (
        input  count,
        output wrap_pulse,
        output wrap_count,
        output stalled,
        output jump_err,
        output state
    );
endinterface

// File: rtl/count_wrap_monitor.sv
// Monitor for a free-running WIDTH-bit counter. Every clock the observed
// count is classified against the previous sample, and wraps, stalls and
// illegal jumps are reported on registered outputs.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | just out of reset; next sample only seeds prev
// TRACK | counter is stepping; consecutive holds are being counted
// STALL | count unchanged for STALL_LIMIT samples; stalled is high
// ERROR | illegal jump seen; everything frozen until reset
module count_wrap_monitor #(
    parameter int WIDTH       = 4,
    parameter int STALL_LIMIT = 8,
    parameter int WRAP_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    count_wrap_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        STALL = 2'b10,
        ERROR = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL   = '1;
    localparam logic [WIDTH-1:0] ZERO_VAL  = '0;
    // STALL_LIMIT is at most 255, so an 8-bit hold counter always suffices.
    localparam logic [7:0]       LIMIT     = 8'(STALL_LIMIT);
    localparam logic [7:0]       LIMIT_M1  = 8'(STALL_LIMIT - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [7:0]        stall_cnt_q, stall_cnt_d;
    logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic              stalled_q, stalled_d;
    logic              jump_err_q, jump_err_d;

    logic [WIDTH-1:0]  count;
    logic              is_step;
    logic              is_wrap;
    logic              is_hold;
    logic              is_restart;

    assign count = bus.count;

    // Classify the current sample against the previous one.
    always_comb begin
        is_step    = (count == WIDTH'(prev_q + 1'b1));
        is_wrap    = (prev_q == MAX_VAL) && (count == ZERO_VAL);
        is_hold    = (count == prev_q);
        // A drop to zero from mid-range is an upstream counter reset, not a wrap.
        is_restart = (count == ZERO_VAL) && (prev_q != MAX_VAL) && (prev_q != ZERO_VAL);
    end

    // State, sample history and all outputs are registered together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            stall_cnt_q  <= '0;
            wrap_count_q <= '0;
            wrap_pulse_q <= 1'b0;
            stalled_q    <= 1'b0;
            jump_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            stall_cnt_q  <= stall_cnt_d;
            wrap_count_q <= wrap_count_d;
            wrap_pulse_q <= wrap_pulse_d;
            stalled_q    <= stalled_d;
            jump_err_q   <= jump_err_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        stall_cnt_d  = stall_cnt_q;
        wrap_count_d = wrap_count_q;
        wrap_pulse_d = 1'b0;
        stalled_d    = stalled_q;
        jump_err_d   = jump_err_q;

        case (state_q)
            IDLE: begin
                prev_d      = count;
                stall_cnt_d = '0;
                stalled_d   = 1'b0;
                state_d     = TRACK;
            end

            TRACK, STALL: begin
                prev_d = count;
                if (is_hold) begin
                    if (state_q == STALL) begin
                        // Counter stays parked at the limit while the hold lasts.
                        stalled_d = 1'b1;
                    end else if (stall_cnt_q == LIMIT_M1) begin
                        state_d     = STALL;
                        stalled_d   = 1'b1;
                        stall_cnt_d = LIMIT;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 8'd1;
                    end
                end else if (is_step || is_restart) begin
                    state_d     = TRACK;
                    stalled_d   = 1'b0;
                    stall_cnt_d = '0;
                    if (is_wrap) begin
                        wrap_pulse_d = 1'b1;
                        if (wrap_count_q != {WRAP_W{1'b1}}) begin
                            wrap_count_d = wrap_count_q + 1'b1;
                        end
                    end
                end else begin
                    state_d    = ERROR;
                    stalled_d  = 1'b0;
                    jump_err_d = 1'b1;
                end
            end

            ERROR: begin
                // Absorbing: prev and wrap_count hold, only reset leaves.
                stalled_d  = 1'b0;
                jump_err_d = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.state      = state_q;
    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.wrap_count = wrap_count_q;
    assign bus.stalled    = stalled_q;
    assign bus.jump_err   = jump_err_q;

endmodule

// File: doc/count_wrap_monitor.md
Name: count_wrap_monitor

Overview:
Downstream consumer of the 4-bit free-running counter in the FSMs group. It samples the counter value every clock and checks that each new value is a legal next step. It reports wrap-around events, keeps a saturating wrap tally, and flags stalls and illegal jumps. All outputs are registered, and it is used as a self-checking monitor alongside the counter.

Parameters:
WIDTH, 4, width of the observed count bus.
STALL_LIMIT, 8, number of consecutive unchanged samples that declares a stall (legal range 2..255).
WRAP_W, 8, width of the saturating wrap tally.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
count  input  WIDTH  counter value under observation, sampled every rising edge.
wrap_pulse  output  1  one-cycle pulse on a legal MAX->0 transition.
wrap_count  output  WRAP_W  saturating number of wraps since reset.
stalled  output  1  high while the count is held unchanged beyond the limit.
jump_err  output  1  sticky flag for an illegal count transition.
state  output  2  current FSM state (IDLE=00, TRACK=01, STALL=10, ERROR=11).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - state=IDLE; wrap_pulse=0; wrap_count=0; stalled=0; jump_err=0.
  - Internal prev register=0; stall counter=0.
  - Reset asserted mid-operation takes effect at the next edge, regardless of state.
- Timing: at each edge, count is compared combinationally with prev. All outputs and state are registered at that same edge and are visible for the following cycle. In every non-ERROR state, prev is loaded with count each edge.
- Step classification, with MAX = 2^WIDTH-1:
  - STEP: count == prev+1 mod 2^WIDTH.
  - WRAP: a STEP with prev==MAX and count==0.
  - HOLD: count == prev.
  - RESTART: count==0 while prev is neither MAX nor 0. Treated as an upstream counter reset: legal, and not a wrap.
  - JUMP: any other transition.
- IDLE: the first edge with reset low captures count into prev and moves to TRACK. No checks are made on that edge.
- TRACK:
  - STEP: stall counter cleared.
  - WRAP: additionally, wrap_pulse=1 for exactly one cycle. wrap_count increments and saturates at 2^WRAP_W-1 (no rollover).
  - RESTART: stall counter cleared; wrap_count unchanged.
  - HOLD: stall counter increments. On the STALL_LIMIT-th consecutive HOLD, go to STALL and set stalled=1.
  - JUMP: go to ERROR and set jump_err=1.
- STALL:
  - HOLD: stay in STALL; stall counter frozen at its limit.
  - STEP, WRAP or RESTART: go to TRACK, set stalled=0 and clear the stall counter. A WRAP here also pulses and increments exactly as in TRACK.
  - JUMP: go to ERROR; stalled=0; jump_err=1.
- ERROR: absorbing until reset.
  - jump_err stays 1.
  - wrap_count is frozen; wrap_pulse=0; stalled=0.
  - prev is not updated.
- Simultaneous events: wrap_pulse and stalled are never high in the same cycle.
- Upstream reset hold: a counter held at 0 by its own reset is a HOLD sequence. stalled therefore asserts after STALL_LIMIT samples; this is intended.
- Priority when reset is high: reset overrides every classification.

Test Plan:
1. Reset for 2 cycles. Ramp count 0,1,...,15,0,1. wrap_pulse is high exactly one cycle, the cycle after 0 is sampled following 15. wrap_count=1; jump_err=0; state=01.
2. Continuous increment for 48 samples starting at 0. wrap_count=2 after the 32nd step; wrap_pulse has exactly 2 one-cycle pulses; stalled never asserts.
3. Ramp to 5, then hold 5 for 10 cycles, then 6. stalled rises after the 8th equal sample and state=10. Sampling 6 clears stalled and returns state=01. wrap_count is unchanged.
4. Ramp 0..3, then count=7. jump_err=1 and state=11 from the next cycle. A following legal ramp through 15->0 gives no wrap_pulse and wrap_count stays frozen. Asserting reset for one edge clears all outputs and returns state=00.
5. WRAP_W=2 with 5 full wraps. wrap_count reads 1,2,3,3,3 (saturated); wrap_pulse still fires on every wrap.
6. Ramp to 9, then count=0 (RESTART). No wrap_pulse and no jump_err; state stays 01. Then hold 0 for 8 cycles to get stalled=1, and assert reset on the 9th. All outputs are 0 after that edge, with state=00.
